// File: rtl/cmplx_frame_accumulator.sv
// cmplx_frame_accumulator
//   Sums LEN consecutive signed complex products (p_r, p_i) into one complex
//   frame result, presented through a valid/ready output register.
//   The next frame keeps accumulating while a result is held; only the final
//   product of a frame stalls, and only while the previous result is unclaimed.
//   Optional feature macro: SATURATE_EN
//     defined   -> every add clips per component; out_sat flags clipped frames
//     undefined -> adds wrap modulo 2^ACC_W; out_sat tied low
module cmplx_frame_accumulator #(
  parameter int unsigned N     = 8,
  parameter int unsigned LEN   = 16,
  parameter int unsigned ACC_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*N-1:0]     p_r,
  input  logic [2*N-1:0]     p_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   sum_r,
  output logic [ACC_W-1:0]   sum_i,
  output logic               out_sat
);

  localparam int unsigned P_W   = 2 * N;
  localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  logic [ACC_W-1:0] acc_r_q, acc_r_d;
  logic [ACC_W-1:0] acc_i_q, acc_i_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] sum_r_q, sum_r_d;
  logic [ACC_W-1:0] sum_i_q, sum_i_d;

  logic signed [P_W-1:0] p_r_s, p_i_s;
  logic [ACC_W-1:0]      ext_r, ext_i;
  logic [ACC_W-1:0]      add_r, add_i;
  logic                  last, accept, handoff;

  // Sign-extend the products to accumulator width
  assign p_r_s = p_r;
  assign p_i_s = p_i;
  assign ext_r = ACC_W'(p_r_s);
  assign ext_i = ACC_W'(p_i_s);

  // Handshake decode
  assign last     = (cnt_q == CNT_LAST);
  assign in_ready = !(last && out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid_q && out_ready;

`ifdef SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, (ACC_W-1)'(0)};
  localparam logic [ACC_W-1:0] ACC_MAX = ~ACC_MIN;

  logic [ACC_W:0] wide_r, wide_i;
  logic           clip_r, clip_i, clip_now;
  logic           sat_flag_q, sat_flag_d;
  logic           out_sat_q, out_sat_d;

  // One guard bit per component; overflow when the two top bits disagree
  assign wide_r   = {acc_r_q[ACC_W-1], acc_r_q} + {ext_r[ACC_W-1], ext_r};
  assign wide_i   = {acc_i_q[ACC_W-1], acc_i_q} + {ext_i[ACC_W-1], ext_i};
  assign clip_r   = wide_r[ACC_W] ^ wide_r[ACC_W-1];
  assign clip_i   = wide_i[ACC_W] ^ wide_i[ACC_W-1];
  assign clip_now = clip_r || clip_i;
  assign add_r    = clip_r ? (wide_r[ACC_W] ? ACC_MIN : ACC_MAX) : wide_r[ACC_W-1:0];
  assign add_i    = clip_i ? (wide_i[ACC_W] ? ACC_MIN : ACC_MAX) : wide_i[ACC_W-1:0];
  assign out_sat  = out_sat_q;
`else
  // Plain two's-complement wrap-around adds
  assign add_r   = acc_r_q + ext_r;
  assign add_i   = acc_i_q + ext_i;
  assign out_sat = 1'b0;
`endif

  // Next-state: accumulate, close the frame on the last product, release on handoff
  always_comb begin
    acc_r_d     = acc_r_q;
    acc_i_d     = acc_i_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    sum_r_d     = sum_r_q;
    sum_i_d     = sum_i_q;
`ifdef SATURATE_EN
    sat_flag_d  = sat_flag_q;
    out_sat_d   = out_sat_q;
`endif
    if (handoff) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (last) begin
        sum_r_d     = add_r;
        sum_i_d     = add_i;
        out_valid_d = 1'b1;
        acc_r_d     = '0;
        acc_i_d     = '0;
        cnt_d       = '0;
`ifdef SATURATE_EN
        out_sat_d   = sat_flag_q || clip_now;
        sat_flag_d  = 1'b0;
`endif
      end else begin
        acc_r_d     = add_r;
        acc_i_d     = add_i;
        cnt_d       = cnt_q + CNT_W'(1);
`ifdef SATURATE_EN
        sat_flag_d  = sat_flag_q || clip_now;
`endif
      end
    end
  end

  // State and output registers; reset discards any partial frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r_q     <= '0;
      acc_i_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      sum_r_q     <= '0;
      sum_i_q     <= '0;
`ifdef SATURATE_EN
      sat_flag_q  <= 1'b0;
      out_sat_q   <= 1'b0;
`endif
    end else begin
      acc_r_q     <= acc_r_d;
      acc_i_q     <= acc_i_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      sum_r_q     <= sum_r_d;
      sum_i_q     <= sum_i_d;
`ifdef SATURATE_EN
      sat_flag_q  <= sat_flag_d;
      out_sat_q   <= out_sat_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign sum_r     = sum_r_q;
  assign sum_i     = sum_i_q;

endmodule

// File: tb/tb_cmplx_frame_accumulator.sv
// Directed bench for cmplx_frame_accumulator (N=8, LEN=4, ACC_W=20 plus an
// ACC_W=16 instance sharing the same stimulus for the overflow case).
module tb_cmplx_frame_accumulator;

  localparam int unsigned N     = 8;
  localparam int unsigned LEN   = 4;
  localparam int unsigned ACC_W = 20;
  localparam int unsigned ACC_S = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   p_r;
  logic [2*N-1:0]   p_i;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum_r;
  logic [ACC_W-1:0] sum_i;
  logic             out_sat;

  logic             in_ready16;
  logic             out_valid16;
  logic [ACC_S-1:0] sum_r16;
  logic [ACC_S-1:0] sum_i16;
  logic             out_sat16;

  int n_checks;
  int n_fail;
  int n_hand;
  int h0;

  cmplx_frame_accumulator #(.N(N), .LEN(LEN), .ACC_W(ACC_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .p_r(p_r), .p_i(p_i), .out_valid(out_valid), .out_ready(out_ready),
    .sum_r(sum_r), .sum_i(sum_i), .out_sat(out_sat)
  );

  cmplx_frame_accumulator #(.N(N), .LEN(LEN), .ACC_W(ACC_S)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .p_r(p_r), .p_i(p_i), .out_valid(out_valid16), .out_ready(out_ready),
    .sum_r(sum_r16), .sum_i(sum_i16), .out_sat(out_sat16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output handoffs of the main instance
  initial n_hand = 0;
  always @(posedge clk) begin
    if (out_valid && out_ready) n_hand <= n_hand + 1;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one product and wait (bounded) for it to be accepted; in_valid stays high
  task automatic send(input int pr, input int pi);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    p_r      = 16'(pr);
    p_i      = 16'(pi);
    while (!in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) chk("in_ready_timeout", 64'(in_ready), 64'sd1);
    @(negedge clk);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    p_r       = '0;
    p_i       = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'sd0);
    chk("rst_sum_r", $signed(sum_r), 64'sd0);
    chk("rst_sum_i", $signed(sum_i), 64'sd0);
    chk("rst_out_sat", 64'(out_sat), 64'sd0);
    chk("rst_in_ready", 64'(in_ready), 64'sd1);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic frame of (1,2)
    h0 = n_hand;
    for (int k = 0; k < 4; k++) send(1, 2);
    chk("t1_out_valid", 64'(out_valid), 64'sd1);
    chk("t1_sum_r", $signed(sum_r), 64'sd4);
    chk("t1_sum_i", $signed(sum_i), 64'sd8);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_out_valid_drop", 64'(out_valid), 64'sd0);
    chk("t1_handoffs", 64'(n_hand - h0), 64'sd1);
    chk("t1_sum_r_kept", $signed(sum_r), 64'sd4);

    // 2: signed products with idle gaps
    send(-16384, 16129);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    send(100, -1);
    in_valid = 1'b0;
    @(negedge clk);
    send(0, 0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    send(-1, -1);
    chk("t2_out_valid", 64'(out_valid), 64'sd1);
    chk("t2_sum_r", $signed(sum_r), -64'sd16285);
    chk("t2_sum_i", $signed(sum_i), 64'sd16127);
    in_valid = 1'b0;
    @(negedge clk);

    // 3: backpressure holds the first result and stalls the last product of frame 2
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(1, 1);
    chk("t3_out_valid", 64'(out_valid), 64'sd1);
    chk("t3_sum_r", $signed(sum_r), 64'sd4);
    for (int k = 0; k < 3; k++) send(1, 1);
    chk("t3_stall", 64'(in_ready), 64'sd0);
    @(negedge clk);
    chk("t3_stall_held", 64'(in_ready), 64'sd0);
    chk("t3_held_valid", 64'(out_valid), 64'sd1);
    chk("t3_held_sum_i", $signed(sum_i), 64'sd4);
    h0 = n_hand;
    out_ready = 1'b1;
    #1;
    chk("t3_ready_release", 64'(in_ready), 64'sd1);
    @(negedge clk);
    chk("t3_b2b_valid", 64'(out_valid), 64'sd1);
    chk("t3_b2b_sum_r", $signed(sum_r), 64'sd4);
    chk("t3_b2b_sum_i", $signed(sum_i), 64'sd4);
    chk("t3_first_handoff", 64'(n_hand - h0), 64'sd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_second_handoff", 64'(n_hand - h0), 64'sd2);
    chk("t3_out_valid_drop", 64'(out_valid), 64'sd0);

    // 4: reset mid-frame discards the partial sum
    send(5, 5);
    send(5, 5);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t4_rst_valid", 64'(out_valid), 64'sd0);
    chk("t4_rst_sum_r", $signed(sum_r), 64'sd0);
    chk("t4_rst_sum_i", $signed(sum_i), 64'sd0);
    chk("t4_rst_sat", 64'(out_sat), 64'sd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) send(3, 0);
    chk("t4_out_valid", 64'(out_valid), 64'sd1);
    chk("t4_sum_r", $signed(sum_r), 64'sd12);
    chk("t4_sum_i", $signed(sum_i), 64'sd0);
    in_valid = 1'b0;
    @(negedge clk);

    // 5: overflow in the 16-bit instance, fits in the 20-bit instance
    for (int k = 0; k < 4; k++) send(16384, -16384);
    chk("t5_w20_sum_r", $signed(sum_r), 64'sd65536);
    chk("t5_w20_sum_i", $signed(sum_i), -64'sd65536);
    chk("t5_w20_sat", 64'(out_sat), 64'sd0);
    chk("t5_w16_valid", 64'(out_valid16), 64'sd1);
`ifdef SATURATE_EN
    chk("t5_w16_sum_r", $signed(sum_r16), 64'sd32767);
    chk("t5_w16_sum_i", $signed(sum_i16), -64'sd32768);
    chk("t5_w16_sat", 64'(out_sat16), 64'sd1);
`else
    chk("t5_w16_sum_r", $signed(sum_r16), 64'sd0);
    chk("t5_w16_sum_i", $signed(sum_i16), 64'sd0);
    chk("t5_w16_sat", 64'(out_sat16), 64'sd0);
`endif
    in_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) send(1, 1);
    chk("t5_clean_sum_r", $signed(sum_r16), 64'sd4);
    chk("t5_clean_sum_i", $signed(sum_i16), 64'sd4);
    chk("t5_clean_sat", 64'(out_sat16), 64'sd0);
    in_valid = 1'b0;
    @(negedge clk);

    // 6: continuous streaming with out_ready held high
    h0 = n_hand;
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1;
      p_r      = 16'(2);
      p_i      = 16'(-2);
      chk("t6_in_ready", 64'(in_ready), 64'sd1);
      @(negedge clk);
      if (k % 4 == 3) begin
        chk("t6_out_valid", 64'(out_valid), 64'sd1);
        chk("t6_sum_r", $signed(sum_r), 64'sd8);
        chk("t6_sum_i", $signed(sum_i), -64'sd8);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_handoffs", 64'(n_hand - h0), 64'sd3);
    chk("t6_out_valid_drop", 64'(out_valid), 64'sd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
